// File: rtl/audio_pkg.sv
// Shared audio definitions: note codes, tone half-period math and the song table format.
package audio_pkg;

    localparam int unsigned HP_W    = 18;
    localparam int unsigned CODE_W  = 4;
    localparam int unsigned DUR_W   = 3;
    localparam int unsigned IDX_W   = 8;
    localparam int unsigned MAX_LEN = 256;

    localparam logic [CODE_W-1:0] NOTE_REST = 4'd0;
    localparam logic [CODE_W-1:0] NOTE_C4   = 4'd1;
    localparam logic [CODE_W-1:0] NOTE_CS4  = 4'd2;
    localparam logic [CODE_W-1:0] NOTE_D4   = 4'd3;
    localparam logic [CODE_W-1:0] NOTE_DS4  = 4'd4;
    localparam logic [CODE_W-1:0] NOTE_E4   = 4'd5;
    localparam logic [CODE_W-1:0] NOTE_F4   = 4'd6;
    localparam logic [CODE_W-1:0] NOTE_FS4  = 4'd7;
    localparam logic [CODE_W-1:0] NOTE_G4   = 4'd8;
    localparam logic [CODE_W-1:0] NOTE_GS4  = 4'd9;
    localparam logic [CODE_W-1:0] NOTE_A4   = 4'd10;
    localparam logic [CODE_W-1:0] NOTE_AS4  = 4'd11;
    localparam logic [CODE_W-1:0] NOTE_B4   = 4'd12;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic [DUR_W-1:0]  dur;
    } song_entry_t;

    typedef song_entry_t [MAX_LEN-1:0] song_t;
    typedef logic [15:0][HP_W-1:0] hp_table_t;

    // Note frequency in hundredths of a hertz; 0 for rest and unused codes.
    function automatic longint unsigned note_centihz(input logic [CODE_W-1:0] code);
        case (code)
            NOTE_C4:  return 64'd26163;
            NOTE_CS4: return 64'd27718;
            NOTE_D4:  return 64'd29366;
            NOTE_DS4: return 64'd31113;
            NOTE_E4:  return 64'd32963;
            NOTE_F4:  return 64'd34923;
            NOTE_FS4: return 64'd36999;
            NOTE_G4:  return 64'd39200;
            NOTE_GS4: return 64'd41530;
            NOTE_A4:  return 64'd44000;
            NOTE_AS4: return 64'd46616;
            NOTE_B4:  return 64'd49388;
            default:  return 64'd0;
        endcase
    endfunction

    // round(clk_hz / (2*f)); only ever evaluated on constants.
    function automatic logic [HP_W-1:0] half_period(input int unsigned clk_hz,
                                                    input logic [CODE_W-1:0] code);
        longint unsigned two_f;
        two_f = 64'd2 * note_centihz(code);
        if (two_f == 64'd0) return '0;
        return HP_W'((64'(clk_hz) * 64'd100 + two_f / 64'd2) / two_f);
    endfunction

    function automatic hp_table_t build_hp_table(input int unsigned clk_hz);
        hp_table_t t;
        for (int i = 0; i < 16; i++) t[i] = half_period(clk_hz, CODE_W'(i));
        return t;
    endfunction

    function automatic song_t default_song();
        song_t s;
        s = '0;
        s[0]  = '{code: NOTE_C4,   dur: 3'd1};
        s[1]  = '{code: NOTE_C4,   dur: 3'd1};
        s[2]  = '{code: NOTE_G4,   dur: 3'd1};
        s[3]  = '{code: NOTE_G4,   dur: 3'd1};
        s[4]  = '{code: NOTE_A4,   dur: 3'd1};
        s[5]  = '{code: NOTE_A4,   dur: 3'd1};
        s[6]  = '{code: NOTE_G4,   dur: 3'd2};
        s[7]  = '{code: NOTE_F4,   dur: 3'd1};
        s[8]  = '{code: NOTE_F4,   dur: 3'd1};
        s[9]  = '{code: NOTE_E4,   dur: 3'd1};
        s[10] = '{code: NOTE_E4,   dur: 3'd1};
        s[11] = '{code: NOTE_D4,   dur: 3'd1};
        s[12] = '{code: NOTE_D4,   dur: 3'd1};
        s[13] = '{code: NOTE_C4,   dur: 3'd2};
        s[14] = '{code: NOTE_REST, dur: 3'd1};
        s[15] = '{code: NOTE_REST, dur: 3'd0};
        return s;
    endfunction

    localparam song_t DEFAULT_SONG = default_song();

endpackage

// File: rtl/note_seq_rom.sv
// Song table lookup; indices at or beyond LEN read back as the END marker.
module note_seq_rom
    import audio_pkg::*;
#(
    parameter int unsigned LEN  = 16,
    parameter song_t       SONG = DEFAULT_SONG
) (
    input  logic [7:0] idx,
    output logic [3:0] code_c,
    output logic [2:0] dur_c
);

    always_comb begin
        code_c = '0;
        dur_c  = '0;
        if (32'(idx) < LEN) begin
            code_c = SONG[idx].code;
            dur_c  = SONG[idx].dur;
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// Melody sequencer: walks the song table and drives tone enable/half-period with articulation gaps.
module note_sequencer
    import audio_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned BEAT_CYCLES = 25_000_000,
    parameter int unsigned GAP_CYCLES  = 1_000_000,
    parameter int unsigned LEN         = 16,
    parameter song_t       SONG        = DEFAULT_SONG
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        loop_en,
    output logic        tone_en,
    output logic [17:0] tone_half_period,
    output logic [3:0]  note_code,
    output logic [7:0]  step_idx,
    output logic        busy,
    output logic        done
);

    localparam int unsigned CNT_W    = $clog2(7 * BEAT_CYCLES);
    localparam hp_table_t   HP_TABLE = build_hp_table(CLK_HZ);

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt, play_cnt;
    logic              past_end, past_end_nxt;
    logic              tone_en_nxt, busy_nxt, done_nxt;
    logic [HP_W-1:0]   hp_nxt;
    logic [CODE_W-1:0] code_nxt, rom_code;
    logic [IDX_W-1:0]  idx_nxt;
    logic [DUR_W-1:0]  rom_dur;

    note_seq_rom #(
        .LEN  (LEN),
        .SONG (SONG)
    ) u_rom (
        .idx    (step_idx),
        .code_c (rom_code),
        .dur_c  (rom_dur)
    );

    // PLAY length reload: dur * BEAT_CYCLES - GAP_CYCLES - 1, selected among constants.
    always_comb begin
        play_cnt = '0;
        for (int d = 1; d <= 7; d++) begin
            if (rom_dur == DUR_W'(d)) play_cnt = CNT_W'(d * BEAT_CYCLES - GAP_CYCLES - 1);
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        past_end_nxt = past_end;
        tone_en_nxt  = 1'b0;
        hp_nxt       = tone_half_period;
        code_nxt     = note_code;
        idx_nxt      = step_idx;
        busy_nxt     = busy;
        done_nxt     = 1'b0;

        if (stop && state != IDLE) begin
            state_nxt    = IDLE;
            cnt_nxt      = '0;
            past_end_nxt = 1'b0;
            hp_nxt       = '0;
            code_nxt     = '0;
            idx_nxt      = '0;
            busy_nxt     = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        state_nxt    = LOAD;
                        idx_nxt      = '0;
                        busy_nxt     = 1'b1;
                        past_end_nxt = 1'b0;
                    end
                end
                LOAD: begin
                    if (past_end || rom_dur == '0) begin
                        past_end_nxt = 1'b0;
                        idx_nxt      = '0;
                        if (!loop_en) begin
                            state_nxt = IDLE;
                            done_nxt  = 1'b1;
                            busy_nxt  = 1'b0;
                            hp_nxt    = '0;
                            code_nxt  = '0;
                        end
                    end else begin
                        state_nxt   = PLAY;
                        code_nxt    = rom_code;
                        hp_nxt      = HP_TABLE[rom_code];
                        cnt_nxt     = play_cnt;
                        tone_en_nxt = (rom_code != '0);
                    end
                end
                PLAY: begin
                    if (cnt == '0) begin
                        state_nxt = GAP;
                        cnt_nxt   = CNT_W'(GAP_CYCLES - 1);
                    end else begin
                        cnt_nxt     = cnt - 1'b1;
                        tone_en_nxt = (note_code != '0);
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        state_nxt    = LOAD;
                        idx_nxt      = step_idx + 1'b1;
                        past_end_nxt = (step_idx == IDX_W'(LEN - 1));
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            cnt              <= '0;
            past_end         <= 1'b0;
            tone_en          <= 1'b0;
            tone_half_period <= '0;
            note_code        <= '0;
            step_idx         <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            state            <= state_nxt;
            cnt              <= cnt_nxt;
            past_end         <= past_end_nxt;
            tone_en          <= tone_en_nxt;
            tone_half_period <= hp_nxt;
            note_code        <= code_nxt;
            step_idx         <= idx_nxt;
            busy             <= busy_nxt;
            done             <= done_nxt;
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: a timeline model pushes per-cycle expectations, a monitor checks them.
`timescale 1ns/1ps
module tb_note_sequencer;
    import audio_pkg::*;

    localparam int unsigned BEAT = 10;
    localparam int unsigned GAPC = 2;
    localparam int unsigned LEN  = 4;

    function automatic song_t tb_song();
        song_t s;
        s = '0;
        s[0] = '{code: NOTE_C4,   dur: 3'd1};
        s[1] = '{code: NOTE_REST, dur: 3'd2};
        s[2] = '{code: NOTE_E4,   dur: 3'd1};
        s[3] = '{code: NOTE_REST, dur: 3'd0};
        return s;
    endfunction

    localparam song_t TB_SONG = tb_song();

    // Reference table: note code and beats per entry, beats 0 = END.
    int m_code [LEN] = '{1, 0, 5, 0};
    int m_dur  [LEN] = '{1, 2, 1, 0};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop_en = 1'b0;
    logic        tone_en;
    logic [17:0] tone_half_period;
    logic [3:0]  note_code;
    logic [7:0]  step_idx;
    logic        busy;
    logic        done;

    note_sequencer #(
        .CLK_HZ      (100_000_000),
        .BEAT_CYCLES (BEAT),
        .GAP_CYCLES  (GAPC),
        .LEN         (LEN),
        .SONG        (TB_SONG)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .stop             (stop),
        .loop_en          (loop_en),
        .tone_en          (tone_en),
        .tone_half_period (tone_half_period),
        .note_code        (note_code),
        .step_idx         (step_idx),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit tone_en;
        int hp;
        int code;
        int idx;
        bit busy;
        bit done;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    // Model: playing flag, entry index k, cycle offset o within the entry (0 = fetch cycle).
    bit m_act = 0;
    int m_k = 0;
    int m_o = 0;
    int m_shown = 0;
    bit m_done = 0;

    function automatic int exp_hp(input int code);
        case (code)
            1:       return 191110;
            5:       return 151685;
            10:      return 113636;
            default: return 0;
        endcase
    endfunction

    function automatic bit entry_ok(input int k);
        return (k < int'(LEN)) && (m_dur[k] != 0);
    endfunction

    task automatic model_reset();
        m_act = 0; m_k = 0; m_o = 0; m_shown = 0; m_done = 0;
    endtask

    task automatic model_edge(input bit r, input bit st, input bit sp, input bit le);
        m_done = 0;
        if (!r) begin
            model_reset();
        end else if (!m_act) begin
            if (st && !sp) begin m_act = 1; m_k = 0; m_o = 0; end
        end else if (sp) begin
            m_act = 0; m_k = 0; m_o = 0; m_shown = 0;
        end else if (!entry_ok(m_k)) begin
            if (le) begin m_k = 0; m_o = 0; end
            else begin m_act = 0; m_k = 0; m_o = 0; m_shown = 0; m_done = 1; end
        end else begin
            m_o++;
            if (m_o == 1) m_shown = m_code[m_k];
            if (m_o == 1 + m_dur[m_k] * int'(BEAT)) begin m_k++; m_o = 0; end
        end
    endtask

    function automatic exp_t exp_now();
        exp_t e;
        e.busy    = m_act;
        e.idx     = m_act ? m_k : 0;
        e.code    = m_shown;
        e.hp      = exp_hp(m_shown);
        e.done    = m_done;
        e.tone_en = m_act && entry_ok(m_k) && m_o >= 1 &&
                    m_o <= m_dur[m_k] * int'(BEAT) - int'(GAPC) && m_code[m_k] != 0;
        return e;
    endfunction

    // One clock: present inputs, let the edge happen, record expectation; arst drops rst_n between edges.
    task automatic cycle(input bit st, input bit sp, input bit le, input bit arst);
        start = st; stop = sp; loop_en = le;
        @(posedge clk);
        model_edge(rst_n, st, sp, le);
        if (arst) model_reset();
        exp_q.push_back(exp_now());
        #1;
        if (arst) rst_n = 1'b0;
        else if (!rst_n) rst_n = 1'b1;
    endtask

    task automatic idle(input int n, input bit le);
        repeat (n) cycle(1'b0, 1'b0, le, 1'b0);
    endtask

    exp_t mon_e;
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                n_cmp++;
                if (tone_en !== mon_e.tone_en || tone_half_period !== 18'(mon_e.hp) ||
                    note_code !== 4'(mon_e.code) || step_idx !== 8'(mon_e.idx) ||
                    busy !== mon_e.busy || done !== mon_e.done) begin
                    n_bad++;
                    $display("FAIL outputs @cycle %0d: got en=%0b hp=%0d code=%0d idx=%0d busy=%0b done=%0b, want en=%0b hp=%0d code=%0d idx=%0d busy=%0b done=%0b",
                             cyc, tone_en, tone_half_period, note_code, step_idx, busy, done,
                             mon_e.tone_en, mon_e.hp, mon_e.code, mon_e.idx, mon_e.busy, mon_e.done);
                end
            end
        end
    end

    initial begin
        idle(3, 1'b0);

        // Full song, no loop, then idle long enough to see done and IDLE.
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        idle(50, 1'b0);

        // Looping playback, then stop while busy.
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        idle(100, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        idle(4, 1'b0);

        // Stop mid-PLAY of C4, then replay from entry 0.
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        idle(4, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        idle(3, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        idle(15, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);

        // start+stop together in IDLE, then start again during PLAY.
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        idle(3, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        idle(45, 1'b0);

        // Async reset in the C4 gap (offset 9 of entry 0).
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        idle(8, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        idle(6, 1'b0);

        // Randomized control traffic.
        for (int i = 0; i < 4000; i++) begin
            cycle(($urandom_range(0, 15) == 0), ($urandom_range(0, 60) == 0),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 300) == 0));
        end
        idle(2, 1'b0);

        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
